// File: rtl/param_wb_cache.sv
// Two-way set-associative write-back, write-allocate cache with LRU replacement.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module param_wb_cache #(
    parameter int ADDR_W     = 10,
    parameter int WORD_W     = 10,
    parameter int LINE_WORDS = 2,
    parameter int SETS       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] FIRST_OFF = '0;
    localparam logic [OFF_W-1:0] LAST_OFF  = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, RESPOND} state_t;
    state_t state;

    logic [1:0][SETS-1:0] valid;
    logic [1:0][SETS-1:0] dirty;
    logic [SETS-1:0]      lru;
    logic [TAG_W-1:0]     tags [2][SETS];
    logic [WORD_W-1:0]    data [2][SETS][LINE_WORDS];

    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              way;
    logic [OFF_W-1:0]  k;
    logic [OFF_W-1:0]  k_nxt;

    logic [TAG_W-1:0] c_tag, r_tag;
    logic [IDX_W-1:0] c_idx, r_idx;
    logic [OFF_W-1:0] c_off, r_off;
    logic             hit0, hit1, hit, hit_way, vic_way;

    always_comb begin
        c_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
        c_idx   = cpu_addr[OFF_W +: IDX_W];
        c_off   = cpu_addr[OFF_W-1:0];
        r_tag   = req_addr[ADDR_W-1 -: TAG_W];
        r_idx   = req_addr[OFF_W +: IDX_W];
        r_off   = req_addr[OFF_W-1:0];
        k_nxt   = k + 1'b1;
        hit0    = valid[1'b0][c_idx] && (tags[1'b0][c_idx] == c_tag);
        hit1    = valid[1'b1][c_idx] && (tags[1'b1][c_idx] == c_tag);
        hit     = hit0 || hit1;
        hit_way = !hit0;
        if (!valid[1'b0][c_idx])      vic_way = 1'b0;
        else if (!valid[1'b1][c_idx]) vic_way = 1'b1;
        else                          vic_way = lru[c_idx];
    end

    // Line storage carries no reset; valid bits alone decide whether it is meaningful.
    always_ff @(posedge clk) begin
        if (state == IDLE && cpu_req && hit && cpu_rw)
            data[hit_way][c_idx][c_off] <= cpu_wdata;
        if (state == ALLOCATE && mem_ready) begin
            if (req_rw && k == r_off) data[way][r_idx][k] <= req_wdata;
            else                      data[way][r_idx][k] <= mem_rdata;
            if (k == LAST_OFF) tags[way][r_idx] <= r_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            lru       <= '0;
            req_rw    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            way       <= 1'b0;
            k         <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            mem_req   <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (cpu_req) begin
                    req_rw    <= cpu_rw;
                    req_addr  <= cpu_addr;
                    req_wdata <= cpu_wdata;
                    k         <= '0;
                    if (hit) begin
                        way            <= hit_way;
                        lru[c_idx]     <= ~hit_way;
                        cpu_ready      <= 1'b1;
                        state          <= RESPOND;
                        if (cpu_rw) begin
                            dirty[hit_way][c_idx] <= 1'b1;
                            cpu_rdata             <= cpu_wdata;
                        end else begin
                            cpu_rdata <= data[hit_way][c_idx][c_off];
                        end
                    end else begin
                        way     <= vic_way;
                        mem_req <= 1'b1;
                        if (valid[vic_way][c_idx] && dirty[vic_way][c_idx]) begin
                            state     <= WRITEBACK;
                            mem_rw    <= 1'b1;
                            mem_addr  <= {tags[vic_way][c_idx], c_idx, FIRST_OFF};
                            mem_wdata <= data[vic_way][c_idx][FIRST_OFF];
                        end else begin
                            state     <= ALLOCATE;
                            mem_rw    <= 1'b0;
                            mem_addr  <= {c_tag, c_idx, FIRST_OFF};
                            mem_wdata <= '0;
                        end
                    end
                end
                WRITEBACK: if (mem_ready) begin
                    if (k == LAST_OFF) begin
                        k         <= '0;
                        state     <= ALLOCATE;
                        mem_rw    <= 1'b0;
                        mem_addr  <= {r_tag, r_idx, FIRST_OFF};
                        mem_wdata <= '0;
                    end else begin
                        k         <= k_nxt;
                        mem_addr  <= {tags[way][r_idx], r_idx, k_nxt};
                        mem_wdata <= data[way][r_idx][k_nxt];
                    end
                end
                ALLOCATE: if (mem_ready) begin
                    if (k == LAST_OFF) begin
                        valid[way][r_idx] <= 1'b1;
                        dirty[way][r_idx] <= req_rw;
                        lru[r_idx]        <= ~way;
                        mem_req           <= 1'b0;
                        mem_addr          <= '0;
                        cpu_ready         <= 1'b1;
                        state             <= RESPOND;
                        // The last word is still in flight, so it comes straight from memory.
                        if (req_rw)                cpu_rdata <= req_wdata;
                        else if (r_off == LAST_OFF) cpu_rdata <= mem_rdata;
                        else                       cpu_rdata <= data[way][r_idx][r_off];
                    end else begin
                        k        <= k_nxt;
                        mem_addr <= {r_tag, r_idx, k_nxt};
                    end
                end
                RESPOND: begin
                    cpu_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && cpu_req) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 16'd1;
            end else if (miss_count != '1) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
